// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Bus widths and handshake encodings mirror the execute stage's define set.
package div_seq_pkg;

    localparam int REG_W  = 32;
    localparam int DREG_W = 64;
    localparam int WORK_W = 65;
    localparam int CNT_W  = 6;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [REG_W-1:0]  ZERO_WORD   = '0;
    localparam logic [DREG_W-1:0] ZERO_DWORD  = '0;
    localparam logic [CNT_W-1:0]  LAST_ITER   = 6'd31;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which the
    // unsigned datapath then treats correctly as 2^31.
    function automatic logic [REG_W-1:0] magnitude(input logic [REG_W-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[REG_W-1]) ? (~v + REG_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift the 65-bit working register left
// and trial-subtract the divisor from its upper 33 bits.
module div_step
    import div_seq_pkg::*;
(
    input  logic [WORK_W-1:0] i_work,
    input  logic [REG_W-1:0]  i_divisor,
    output logic [WORK_W-1:0] o_work,
    output logic              o_qbit
);

    logic [REG_W+2:0] w_diff;

    always_comb begin
        // i_work[64:31] is the shifted upper part, extended by one sign bit.
        w_diff = {1'b0, i_work[WORK_W-1:REG_W-1]} - {3'b000, i_divisor};
        // The partial remainder is always below 2^33, so a valid difference
        // has both top bits clear; a borrow sets both.
        o_qbit = ~(|w_diff[REG_W+2:REG_W+1]);
        if (o_qbit) begin
            o_work = {w_diff[REG_W:0], i_work[REG_W-2:0], 1'b1};
        end else begin
            o_work = {i_work[WORK_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU (one quotient bit/cycle).
// Optional macro DIV_EARLY_EXIT_EN: finish in two edges when |dividend| < |divisor|.
module div_seq
    import div_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [REG_W-1:0]  opdata1_i,
    input  logic [REG_W-1:0]  opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [DREG_W-1:0] result_o,
    output logic              ready_o
);

    div_state_e          r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [WORK_W-1:0]   r_work, w_work;
    logic [REG_W-1:0]    r_divisor, w_divisor;
    logic                r_sign1, w_sign1;
    logic                r_sign2, w_sign2;
    logic                r_signed, w_signed;
    logic [DREG_W-1:0]   r_result, w_result;
    logic                r_ready, w_ready;

    logic [REG_W-1:0]    w_mag1, w_mag2;
    logic                w_early;
    logic [WORK_W-1:0]   w_step;
    logic                w_qbit;

    function automatic logic [DREG_W-1:0] fixup(input logic [DREG_W-1:0] work,
                                                input logic              sg,
                                                input logic              s1,
                                                input logic              s2);
        logic [REG_W-1:0] q;
        logic [REG_W-1:0] r;
        q = work[REG_W-1:0];
        r = work[DREG_W-1:REG_W];
        if (sg && (s1 ^ s2)) q = ~q + REG_W'(1);
        if (sg && s1)        r = ~r + REG_W'(1);
        return {r, q};
    endfunction

    div_step u_step (
        .i_work    (r_work),
        .i_divisor (r_divisor),
        .o_work    (w_step),
        .o_qbit    (w_qbit)
    );

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_work    = r_work;
        w_divisor = r_divisor;
        w_sign1   = r_sign1;
        w_sign2   = r_sign2;
        w_signed  = r_signed;
        w_result  = r_result;
        w_ready   = r_ready;

        w_mag1 = magnitude(opdata1_i, signed_div_i);
        w_mag2 = magnitude(opdata2_i, signed_div_i);
`ifdef DIV_EARLY_EXIT_EN
        w_early = (w_mag1 < w_mag2);
`else
        w_early = 1'b0;
`endif

        unique case (r_state)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    w_sign1   = opdata1_i[REG_W-1];
                    w_sign2   = opdata2_i[REG_W-1];
                    w_signed  = signed_div_i;
                    w_divisor = w_mag2;
                    w_cnt     = '0;
                    // ByZero doubles as the one-cycle finish for early exit:
                    // the working register already holds {rem, quot}.
                    if (opdata2_i == ZERO_WORD) begin
                        w_state = DIV_BY_ZERO;
                        w_work  = '0;
                    end else if (w_early) begin
                        w_state = DIV_BY_ZERO;
                        w_work  = {1'b0, w_mag1, ZERO_WORD};
                    end else begin
                        w_state = DIV_ON;
                        w_work  = {1'b0, ZERO_WORD, w_mag1};
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i || start_i == DIV_STOP) begin
                    w_state = DIV_FREE;
                end else begin
                    w_state  = DIV_END;
                    w_result = fixup(r_work[DREG_W-1:0], r_signed, r_sign1, r_sign2);
                    w_ready  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i || start_i == DIV_STOP) begin
                    w_state = DIV_FREE;
                end else begin
                    w_work = w_step;
                    w_cnt  = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_ITER) begin
                        w_state  = DIV_END;
                        w_result = fixup(w_step[DREG_W-1:0], r_signed, r_sign1, r_sign2);
                        w_ready  = DIV_RESULT_READY;
                    end
                end
            end
            DIV_END: begin
                if (annul_i || start_i == DIV_STOP) begin
                    w_state  = DIV_FREE;
                    w_result = ZERO_DWORD;
                    w_ready  = DIV_RESULT_NOT_READY;
                end
            end
            default: begin
                w_state  = DIV_FREE;
                w_result = ZERO_DWORD;
                w_ready  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= DIV_FREE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_signed  <= 1'b0;
            r_result  <= ZERO_DWORD;
            r_ready   <= DIV_RESULT_NOT_READY;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_work    <= w_work;
            r_divisor <= w_divisor;
            r_sign1   <= w_sign1;
            r_sign2   <= w_sign2;
            r_signed  <= w_signed;
            r_result  <= w_result;
            r_ready   <= w_ready;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

    // Qbit is folded into w_step; kept as a named net for debug visibility.
    logic w_qbit_unused;
    assign w_qbit_unused = w_qbit;

endmodule
